pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 31 +++
 rtl/ld_use_det.sv | 29 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
// Purpose: FSM state encodings, default data-memory wait limit, the
// stall/clear control bundle type and a counter-width helper.
package pipe_ctrl_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  // Data-memory wait cycles tolerated before the timeout flag is raised
  localparam int MAX_WAIT_DEF = 15;

  // Pipe-register control bundle: stalls hold a stage, clears insert a bubble
  typedef struct packed {
    logic stall_if;
    logic stall_iss;
    logic stall_ex;
    logic stall_mem;
    logic clr_iss;
    logic clr_ex;
  } ctl_t;

  // Wait counter is at least 4 bits and wide enough to hold max_wait
  function automatic int wait_cnt_w(input int max_wait);
    int w;
    w = $clog2(max_wait + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/ld_use_det.sv
// rtl/ld_use_det.sv - combinational load-use hazard compare
// Purpose: flags when the instruction in issue reads the destination of a
// load currently in EX. Register x0 never creates a hazard.
// Ports:
//   ld_ex_i       - a load occupies EX
//   rd_ex_i       - destination register of the EX instruction
//   rs1_iss_i     - source register 1 of the issue instruction
//   rs2_iss_i     - source register 2 of the issue instruction
//   rs_used_iss_i - [0] rs1 is read, [1] rs2 is read
//   ld_use_o      - load-use hazard present
module ld_use_det (
  input  logic       ld_ex_i,
  input  logic [4:0] rd_ex_i,
  input  logic [4:0] rs1_iss_i,
  input  logic [4:0] rs2_iss_i,
  input  logic [1:0] rs_used_iss_i,
  output logic       ld_use_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_rd_nz;

  assign w_rd_nz   = (rd_ex_i != 5'd0);
  assign w_rs1_hit = (rs1_iss_i == rd_ex_i) & rs_used_iss_i[0];
  assign w_rs2_hit = (rs2_iss_i == rd_ex_i) & rs_used_iss_i[1];
  assign ld_use_o  = ld_ex_i & w_rd_nz & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller
// Purpose: generates pipe-register hold (stall) and bubble (clr) controls for
// data-memory waits, branch mispredict flushes and load-use hazards, plus a
// sticky memory-wait timeout flag and saturating stall/flush counters.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   rs1/rs2_iss_i     - issue-stage source registers
//   rs_used_iss_i     - issue-stage source-read enables
//   ld_ex_i, rd_ex_i  - load in EX and its destination
//   brn_mispred_ex_i  - EX resolved a mispredict
//   dmem_req_mem_i    - MEM access pending
//   dmem_ack_i        - memory completes the access
//   stall_*_o         - hold pipe register contents
//   clr_iss_o/clr_ex_o- insert bubble into pipe register
//   mem_timeout_o     - sticky memory-wait timeout
//   stall_cnt_o       - cycles with issue stalled (saturating)
//   flush_cnt_o       - mispredict flushes taken (saturating)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_iss_i,
  input  logic [4:0]  rs2_iss_i,
  input  logic [1:0]  rs_used_iss_i,
  input  logic        ld_ex_i,
  input  logic [4:0]  rd_ex_i,
  input  logic        brn_mispred_ex_i,
  input  logic        dmem_req_mem_i,
  input  logic        dmem_ack_i,
  output logic        stall_if_o,
  output logic        stall_iss_o,
  output logic        stall_ex_o,
  output logic        stall_mem_o,
  output logic        clr_iss_o,
  output logic        clr_ex_o,
  output logic        mem_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int CW = wait_cnt_w(MAX_WAIT);
  localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

  logic [1:0]    r_state;
  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;
  logic [31:0]   r_stall_cnt;
  logic [31:0]   r_flush_cnt;

  logic [1:0]    w_state_nxt;
  logic          w_mem_stall;
  logic          w_ld_use;
  logic          w_mp_take;
  logic          w_wait_step;
  logic [CW-1:0] w_wait_inc;
  ctl_t          w_ctl;

  ld_use_det u_ld_use_det (
    .ld_ex_i       (ld_ex_i),
    .rd_ex_i       (rd_ex_i),
    .rs1_iss_i     (rs1_iss_i),
    .rs2_iss_i     (rs2_iss_i),
    .rs_used_iss_i (rs_used_iss_i),
    .ld_use_o      (w_ld_use)
  );

  assign w_mem_stall = dmem_req_mem_i & ~dmem_ack_i;

  always_comb begin
    w_ctl       = '0;
    w_state_nxt = r_state;
    w_mp_take   = 1'b0;
    if (w_mem_stall) begin
      // Memory wait freezes the whole pipe; any pending flush or bubble
      // is deferred because EX/ISS contents are held in place.
      w_ctl.stall_if  = 1'b1;
      w_ctl.stall_iss = 1'b1;
      w_ctl.stall_ex  = 1'b1;
      w_ctl.stall_mem = 1'b1;
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_MEM_WAIT;
      end
    end else begin
      case (r_state)
        ST_FLUSH: begin
          // Kill the wrong-path fetch returned by the synchronous imem
          w_ctl.clr_iss = 1'b1;
          w_state_nxt   = ST_RUN;
        end
        default: begin
          // RUN, or the ack cycle of MEM_WAIT: the EX instruction that was
          // held during the wait is now live, so it is resolved here.
          w_state_nxt = ST_RUN;
          if (brn_mispred_ex_i) begin
            w_ctl.clr_iss = 1'b1;
            w_ctl.clr_ex  = 1'b1;
            w_mp_take     = 1'b1;
            w_state_nxt   = ST_FLUSH;
          end else if (w_ld_use) begin
            w_ctl.stall_if  = 1'b1;
            w_ctl.stall_iss = 1'b1;
            w_ctl.clr_ex    = 1'b1;
          end
        end
      endcase
    end
  end

  // Wait counter advances on each stalled cycle spent in MEM_WAIT and
  // saturates at the limit so it never wraps back below it.
  assign w_wait_step = (r_state == ST_MEM_WAIT) & w_mem_stall & (r_wait_cnt != WAIT_LIM);
  assign w_wait_inc  = r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_RUN) && w_mem_stall) begin
        r_wait_cnt <= '0;
      end else if (w_wait_step) begin
        r_wait_cnt <= w_wait_inc;
        if (w_wait_inc == WAIT_LIM) begin
          r_timeout <= 1'b1;
        end
      end
      if (w_ctl.stall_iss && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_mp_take && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  // Controls are forced idle while reset is asserted
  assign stall_if_o    = w_ctl.stall_if  & ~reset;
  assign stall_iss_o   = w_ctl.stall_iss & ~reset;
  assign stall_ex_o    = w_ctl.stall_ex  & ~reset;
  assign stall_mem_o   = w_ctl.stall_mem & ~reset;
  assign clr_iss_o     = w_ctl.clr_iss   & ~reset;
  assign clr_ex_o      = w_ctl.clr_ex    & ~reset;
  assign mem_timeout_o = r_timeout;
  assign stall_cnt_o   = r_stall_cnt;
  assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_iss_i, rs2_iss_i, rd_ex_i;
  logic [1:0]  rs_used_iss_i;
  logic        ld_ex_i, brn_mispred_ex_i, dmem_req_mem_i, dmem_ack_i;
  logic        stall_if_o, stall_iss_o, stall_ex_o, stall_mem_o;
  logic        clr_iss_o, clr_ex_o, mem_timeout_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [5:0]  w_ctl;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MAX_WAIT(15)) dut (
    .clk              (clk),
    .reset            (reset),
    .rs1_iss_i        (rs1_iss_i),
    .rs2_iss_i        (rs2_iss_i),
    .rs_used_iss_i    (rs_used_iss_i),
    .ld_ex_i          (ld_ex_i),
    .rd_ex_i          (rd_ex_i),
    .brn_mispred_ex_i (brn_mispred_ex_i),
    .dmem_req_mem_i   (dmem_req_mem_i),
    .dmem_ack_i       (dmem_ack_i),
    .stall_if_o       (stall_if_o),
    .stall_iss_o      (stall_iss_o),
    .stall_ex_o       (stall_ex_o),
    .stall_mem_o      (stall_mem_o),
    .clr_iss_o        (clr_iss_o),
    .clr_ex_o         (clr_ex_o),
    .mem_timeout_o    (mem_timeout_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  assign w_ctl = {stall_if_o, stall_iss_o, stall_ex_o, stall_mem_o, clr_iss_o, clr_ex_o};

  // Expected control patterns {stall_if, stall_iss, stall_ex, stall_mem, clr_iss, clr_ex}
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_MEM  = 6'b111100;
  localparam logic [5:0] C_LU   = 6'b110001;
  localparam logic [5:0] C_MP   = 6'b000011;
  localparam logic [5:0] C_FL   = 6'b000010;

  typedef struct packed {
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] used;
    logic       mp;
    logic       req;
    logic       ack;
    logic [5:0] exp;
    logic       tmo;
  } step_t;

  step_t       exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_stall = 32'd0;
  logic [31:0] m_flush = 32'd0;

  function automatic step_t mk(input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [1:0] used, input logic mp,
                               input logic req, input logic ack, input logic [5:0] exp,
                               input logic tmo);
    step_t s;
    s.ld = ld; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.used = used;
    s.mp = mp; s.req = req; s.ack = ack; s.exp = exp; s.tmo = tmo;
    return s;
  endfunction

  task automatic set_idle();
    ld_ex_i = 1'b0; rd_ex_i = 5'd0; rs1_iss_i = 5'd0; rs2_iss_i = 5'd0;
    rs_used_iss_i = 2'b00; brn_mispred_ex_i = 1'b0; dmem_req_mem_i = 1'b0; dmem_ack_i = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show for it
  task automatic drive(input step_t s);
    @(posedge clk); #1;
    ld_ex_i = s.ld; rd_ex_i = s.rd; rs1_iss_i = s.rs1; rs2_iss_i = s.rs2;
    rs_used_iss_i = s.used; brn_mispred_ex_i = s.mp; dmem_req_mem_i = s.req; dmem_ack_i = s.ack;
    exp_q.push_back(s);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_idle();
    @(posedge clk); #1;
    reset = 1'b0;
    m_stall = 32'd0;
    m_flush = 32'd0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    ld_ex_i = 1'b1; rd_ex_i = 5'd5; rs1_iss_i = 5'd5; rs_used_iss_i = 2'b01;
    brn_mispred_ex_i = 1'b1; dmem_req_mem_i = 1'b1; dmem_ack_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL reset_ctl got %b want %b", w_ctl, C_NONE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_idle();
    m_stall = 32'd0;
    m_flush = 32'd0;
    @(negedge clk);
    n_checks += 4;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL reset_idle_ctl got %b want %b", w_ctl, C_NONE);
    end
    if (mem_timeout_o !== 1'b0) begin
      n_errors++; $display("FAIL reset_timeout got %b want 0", mem_timeout_o);
    end
    if (stall_cnt_o !== 32'd0) begin
      n_errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt_o);
    end
    if (flush_cnt_o !== 32'd0) begin
      n_errors++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt_o);
    end
  endtask

  task automatic test_load_use();
    step_t seq[$];
    step_t e;
    seq.push_back(mk(1, 5'd5, 5'd5, 5'd0, 2'b01, 0, 0, 0, C_LU,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    seq.push_back(mk(1, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, C_NONE, 0));
    seq.push_back(mk(1, 5'd5, 5'd5, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    seq.push_back(mk(1, 5'd7, 5'd3, 5'd7, 2'b10, 0, 0, 0, C_LU,   0));
    seq.push_back(mk(1, 5'd7, 5'd3, 5'd7, 2'b01, 0, 0, 0, C_NONE, 0));
    seq.push_back(mk(0, 5'd5, 5'd5, 5'd5, 2'b11, 0, 0, 0, C_NONE, 0));
    seq.push_back(mk(1, 5'd9, 5'd9, 5'd9, 2'b11, 0, 0, 0, C_LU,   0));
    seq.push_back(mk(1, 5'd9, 5'd9, 5'd9, 2'b11, 0, 0, 0, C_LU,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    foreach (seq[k]) begin
      drive(seq[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks += 4;
      if (w_ctl !== e.exp) begin
        n_errors++; $display("FAIL load_use[%0d] ctl got %b want %b", k, w_ctl, e.exp);
      end
      if (mem_timeout_o !== e.tmo) begin
        n_errors++; $display("FAIL load_use[%0d] timeout got %b want %b", k, mem_timeout_o, e.tmo);
      end
      if (stall_cnt_o !== m_stall) begin
        n_errors++; $display("FAIL load_use[%0d] stall_cnt got %0d want %0d", k, stall_cnt_o, m_stall);
      end
      if (flush_cnt_o !== m_flush) begin
        n_errors++; $display("FAIL load_use[%0d] flush_cnt got %0d want %0d", k, flush_cnt_o, m_flush);
      end
      if (e.exp[4]) m_stall++;
      if (e.exp == C_MP) m_flush++;
    end
  endtask

  task automatic test_mispredict();
    step_t seq[$];
    step_t e;
    // plain pulse: clr both, then clr_iss only, then normal
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, C_MP,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_FL,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    // mispredict beats a coincident load-use; hazard ignored in FLUSH
    seq.push_back(mk(1, 5'd4, 5'd4, 5'd0, 2'b01, 1, 0, 0, C_MP,   0));
    seq.push_back(mk(1, 5'd4, 5'd4, 5'd0, 2'b01, 0, 0, 0, C_FL,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    // memory wait during FLUSH defers the clr
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 0, 0, C_MP,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_MEM,  0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_MEM,  0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 1, C_FL,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    foreach (seq[k]) begin
      drive(seq[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks += 4;
      if (w_ctl !== e.exp) begin
        n_errors++; $display("FAIL mispredict[%0d] ctl got %b want %b", k, w_ctl, e.exp);
      end
      if (mem_timeout_o !== e.tmo) begin
        n_errors++; $display("FAIL mispredict[%0d] timeout got %b want %b", k, mem_timeout_o, e.tmo);
      end
      if (stall_cnt_o !== m_stall) begin
        n_errors++; $display("FAIL mispredict[%0d] stall_cnt got %0d want %0d", k, stall_cnt_o, m_stall);
      end
      if (flush_cnt_o !== m_flush) begin
        n_errors++; $display("FAIL mispredict[%0d] flush_cnt got %0d want %0d", k, flush_cnt_o, m_flush);
      end
      if (e.exp[4]) m_stall++;
      if (e.exp == C_MP) m_flush++;
    end
  endtask

  task automatic test_mem_wait();
    step_t seq[$];
    step_t e;
    for (int i = 0; i < 3; i++) seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_MEM, 0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 1, C_NONE, 0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    // zero-wait accesses stay in RUN; load-use still detected alongside
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 1, C_NONE, 0));
    seq.push_back(mk(1, 5'd6, 5'd0, 5'd6, 2'b10, 0, 1, 1, C_LU,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    foreach (seq[k]) begin
      drive(seq[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks += 4;
      if (w_ctl !== e.exp) begin
        n_errors++; $display("FAIL mem_wait[%0d] ctl got %b want %b", k, w_ctl, e.exp);
      end
      if (mem_timeout_o !== e.tmo) begin
        n_errors++; $display("FAIL mem_wait[%0d] timeout got %b want %b", k, mem_timeout_o, e.tmo);
      end
      if (stall_cnt_o !== m_stall) begin
        n_errors++; $display("FAIL mem_wait[%0d] stall_cnt got %0d want %0d", k, stall_cnt_o, m_stall);
      end
      if (flush_cnt_o !== m_flush) begin
        n_errors++; $display("FAIL mem_wait[%0d] flush_cnt got %0d want %0d", k, flush_cnt_o, m_flush);
      end
      if (e.exp[4]) m_stall++;
      if (e.exp == C_MP) m_flush++;
    end
  endtask

  task automatic test_back_to_back();
    step_t seq[$];
    step_t e;
    // mispredict + load-use under a memory wait: stalls only, flush after ack
    seq.push_back(mk(1, 5'd5, 5'd5, 5'd0, 2'b01, 1, 1, 0, C_MEM,  0));
    seq.push_back(mk(1, 5'd5, 5'd5, 5'd0, 2'b01, 1, 1, 0, C_MEM,  0));
    seq.push_back(mk(1, 5'd5, 5'd5, 5'd0, 2'b01, 1, 1, 1, C_MP,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_FL,   0));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 0));
    foreach (seq[k]) begin
      drive(seq[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks += 4;
      if (w_ctl !== e.exp) begin
        n_errors++; $display("FAIL back_to_back[%0d] ctl got %b want %b", k, w_ctl, e.exp);
      end
      if (mem_timeout_o !== e.tmo) begin
        n_errors++; $display("FAIL back_to_back[%0d] timeout got %b want %b", k, mem_timeout_o, e.tmo);
      end
      if (stall_cnt_o !== m_stall) begin
        n_errors++; $display("FAIL back_to_back[%0d] stall_cnt got %0d want %0d", k, stall_cnt_o, m_stall);
      end
      if (flush_cnt_o !== m_flush) begin
        n_errors++; $display("FAIL back_to_back[%0d] flush_cnt got %0d want %0d", k, flush_cnt_o, m_flush);
      end
      if (e.exp[4]) m_stall++;
      if (e.exp == C_MP) m_flush++;
    end
  endtask

  task automatic test_timeout();
    step_t seq[$];
    step_t e;
    do_reset();
    // wait count is 0 after the first stalled cycle and reaches 15 after
    // the 16th, so the flag is visible from the 17th stalled cycle
    for (int i = 1; i <= 20; i++) begin
      seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 0, C_MEM, (i >= 17) ? 1'b1 : 1'b0));
    end
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 1, 1, C_NONE, 1));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 1));
    seq.push_back(mk(0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 0, C_NONE, 1));
    foreach (seq[k]) begin
      drive(seq[k]);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks += 4;
      if (w_ctl !== e.exp) begin
        n_errors++; $display("FAIL timeout[%0d] ctl got %b want %b", k, w_ctl, e.exp);
      end
      if (mem_timeout_o !== e.tmo) begin
        n_errors++; $display("FAIL timeout[%0d] timeout got %b want %b", k, mem_timeout_o, e.tmo);
      end
      if (stall_cnt_o !== m_stall) begin
        n_errors++; $display("FAIL timeout[%0d] stall_cnt got %0d want %0d", k, stall_cnt_o, m_stall);
      end
      if (flush_cnt_o !== m_flush) begin
        n_errors++; $display("FAIL timeout[%0d] flush_cnt got %0d want %0d", k, flush_cnt_o, m_flush);
      end
      if (e.exp[4]) m_stall++;
      if (e.exp == C_MP) m_flush++;
    end
    do_reset();
    @(negedge clk);
    n_checks += 2;
    if (mem_timeout_o !== 1'b0) begin
      n_errors++; $display("FAIL timeout_reset got %b want 0", mem_timeout_o);
    end
    if (stall_cnt_o !== 32'd0) begin
      n_errors++; $display("FAIL timeout_reset_stall_cnt got %0d want 0", stall_cnt_o);
    end
  endtask

  task automatic test_reset_abandon();
    // reset during FLUSH: the pending clr_iss must not appear afterwards
    @(posedge clk); #1;
    set_idle();
    brn_mispred_ex_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_ctl !== C_MP) begin
      n_errors++; $display("FAIL abandon_flush_mp got %b want %b", w_ctl, C_MP);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    n_checks++;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL abandon_flush_in_reset got %b want %b", w_ctl, C_NONE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL abandon_flush_after got %b want %b", w_ctl, C_NONE);
    end
    if (flush_cnt_o !== 32'd0) begin
      n_errors++; $display("FAIL abandon_flush_cnt got %0d want 0", flush_cnt_o);
    end
    // reset during MEM_WAIT with the request still pending: outputs idle in reset
    @(posedge clk); #1;
    dmem_req_mem_i = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL abandon_mem_in_reset got %b want %b", w_ctl, C_NONE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dmem_ack_i = 1'b1;
    @(negedge clk);
    n_checks += 2;
    if (w_ctl !== C_NONE) begin
      n_errors++; $display("FAIL abandon_mem_after got %b want %b", w_ctl, C_NONE);
    end
    if (stall_cnt_o !== 32'd0) begin
      n_errors++; $display("FAIL abandon_mem_stall_cnt got %0d want 0", stall_cnt_o);
    end
    @(posedge clk); #1;
    set_idle();
  endtask

  initial begin
    reset = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mispredict();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_abandon();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
